decode_stage: RTL and testbench

Decode stage of the five-stage pipeline, directly downstream of the fetch stage. Consumes the IF/ID register (instruction, 5-bit PC, prediction, BTB hit, GHR snapshot), reads the 32×32 register file, generates control, computes the branch target written into the BTB, detects load-use hazards (stalling fetch), and holds the ID/EX pipeline register. It also hosts the register-file write port driven by write-back.

---
 rtl/decode_stage_if.sv | 51 +++++
 rtl/decode_stage.sv | 166 ++++++++++++++++
 tb/tb_decode_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Bundles every non-clock/reset signal of the decode stage.
//   master : the surrounding pipeline (fetch, HDU, write-back, execute side)
//   slave  : decode_stage itself
//   IF/ID inputs : Instr_D, Pc_D, prediction_D, hit_D, GHR_D
//   HDU input    : flush_E
//   WB inputs    : RegWrite_W, WriteReg_W, Result_W
//   Comb outputs : opcode_D, targetAddress_D, IF_ID_write, PC_WRite
//   ID/EX outputs: RD1_E .. RegDst_E
interface decode_stage_if;
  logic [31:0] Instr_D;
  logic [4:0]  Pc_D;
  logic        prediction_D;
  logic        hit_D;
  logic [3:0]  GHR_D;
  logic        flush_E;
  logic        RegWrite_W;
  logic [4:0]  WriteReg_W;
  logic [31:0] Result_W;

  logic [5:0]  opcode_D;
  logic [31:0] targetAddress_D;
  logic        IF_ID_write;
  logic        PC_WRite;

  logic [31:0] RD1_E, RD2_E, Imm_E;
  logic [4:0]  Rs_E, Rt_E, Rd_E, Pc_E;
  logic [5:0]  functJR_E;
  logic [3:0]  Pc_Xor_GR_E;
  logic [1:0]  ALUOp_E;
  logic        rtype_E, branch_E, bne_E, prediction_E, hit_E, RegWrite_E;
  logic        MemRead_E, MemWrite_E, MemtoReg_E, ALUSrc_E, RegDst_E;

  modport master (
    output Instr_D, Pc_D, prediction_D, hit_D, GHR_D, flush_E,
           RegWrite_W, WriteReg_W, Result_W,
    input  opcode_D, targetAddress_D, IF_ID_write, PC_WRite,
           RD1_E, RD2_E, Imm_E, Rs_E, Rt_E, Rd_E, Pc_E, functJR_E, Pc_Xor_GR_E,
           ALUOp_E, rtype_E, branch_E, bne_E, prediction_E, hit_E, RegWrite_E,
           MemRead_E, MemWrite_E, MemtoReg_E, ALUSrc_E, RegDst_E
  );

  modport slave (
    input  Instr_D, Pc_D, prediction_D, hit_D, GHR_D, flush_E,
           RegWrite_W, WriteReg_W, Result_W,
    output opcode_D, targetAddress_D, IF_ID_write, PC_WRite,
           RD1_E, RD2_E, Imm_E, Rs_E, Rt_E, Rd_E, Pc_E, functJR_E, Pc_Xor_GR_E,
           ALUOp_E, rtype_E, branch_E, bne_E, prediction_E, hit_E, RegWrite_E,
           MemRead_E, MemWrite_E, MemtoReg_E, ALUSrc_E, RegDst_E
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
//   Decode stage of the five-stage pipeline: decodes the IF/ID instruction,
//   reads the 32x32 register file (write port driven by write-back), computes
//   the branch target, detects load-use hazards and holds the ID/EX register.
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high; clears register file and ID/EX
//   io_dec : decode_stage_if.slave, all data/control signals
// Build option:
//   DECODE_WB_BYPASS_EN : when defined, a write-back to the register being
//   read is returned by the read port in the same cycle.
module decode_stage #(
  parameter int RF_DEPTH = 32,
  parameter int PC_W     = 5,
  parameter int GHR_W    = 4
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave io_dec
);

  typedef struct packed {
    logic       rtype;
    logic       branch;
    logic       bne;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  // Field extraction
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_imm_ext;
  assign w_opcode  = io_dec.Instr_D[31:26];
  assign w_rs      = io_dec.Instr_D[25:21];
  assign w_rt      = io_dec.Instr_D[20:16];
  assign w_rd      = io_dec.Instr_D[15:11];
  assign w_imm_ext = {{16{io_dec.Instr_D[15]}}, io_dec.Instr_D[15:0]};

  // Control decode; unknown opcodes fall through as a NOP
  ctrl_t w_ctrl;
  always_comb begin
    w_ctrl = '0;
    case (w_opcode)
      6'h00: begin w_ctrl.reg_write = 1'b1; w_ctrl.reg_dst = 1'b1;
                   w_ctrl.rtype = 1'b1; w_ctrl.alu_op = 2'b10; end
      6'h08: begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1; end
      6'h23: begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1;
                   w_ctrl.mem_read = 1'b1; w_ctrl.mem_to_reg = 1'b1; end
      6'h2B: begin w_ctrl.alu_src = 1'b1; w_ctrl.mem_write = 1'b1; end
      6'h04: begin w_ctrl.branch = 1'b1; w_ctrl.alu_op = 2'b01; end
      6'h05: begin w_ctrl.branch = 1'b1; w_ctrl.bne = 1'b1; w_ctrl.alu_op = 2'b01; end
      default: w_ctrl = '0;
    endcase
  end

  // Branch target, wraps modulo 2^32
  assign io_dec.opcode_D        = w_opcode;
  assign io_dec.targetAddress_D = {{(32-PC_W){1'b0}}, io_dec.Pc_D} + 32'd1 + w_imm_ext;

  // Register file: flop array so reset can clear every entry in one edge.
  // Entry 0 is never written; reads of index 0 are forced to zero below.
  logic [31:0] r_rf [0:RF_DEPTH-1];
  genvar gi;
  generate
    for (gi = 0; gi < RF_DEPTH; gi++) begin : g_rf
      always_ff @(posedge clk) begin
        if (reset)
          r_rf[gi] <= '0;
        else if (io_dec.RegWrite_W && (io_dec.WriteReg_W != 5'd0) &&
                 (io_dec.WriteReg_W == 5'(gi)))
          r_rf[gi] <= io_dec.Result_W;
      end
    end
  endgenerate

  logic [31:0] w_rd1, w_rd2;
  always_comb begin
    w_rd1 = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
    w_rd2 = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
`ifdef DECODE_WB_BYPASS_EN
    if (io_dec.RegWrite_W && (io_dec.WriteReg_W != 5'd0)) begin
      if (io_dec.WriteReg_W == w_rs) w_rd1 = io_dec.Result_W;
      if (io_dec.WriteReg_W == w_rt) w_rd2 = io_dec.Result_W;
    end
`endif
  end

  // ID/EX register
  ctrl_t       r_ctrl_E;
  logic [31:0] r_rd1_E, r_rd2_E, r_imm_E;
  logic [4:0]  r_rs_E, r_rt_E, r_rd_E, r_pc_E;
  logic [5:0]  r_funct_E;
  logic [GHR_W-1:0] r_pxg_E;
  logic        r_pred_E, r_hit_E;

  // Load-use hazard. rt is only a true source for R-type, branches and sw;
  // a flush kills the consumer, so it must not also freeze the front end.
  logic w_uses_rt, w_stall;
  assign w_uses_rt = (w_opcode == 6'h00) || (w_opcode == 6'h04) ||
                     (w_opcode == 6'h05) || (w_opcode == 6'h2B);
  assign w_stall   = r_ctrl_E.mem_read && (r_rt_E != 5'd0) &&
                     ((r_rt_E == w_rs) || ((r_rt_E == w_rt) && w_uses_rt)) &&
                     !io_dec.flush_E;

  assign io_dec.IF_ID_write = ~w_stall;
  assign io_dec.PC_WRite    = ~w_stall;

  always_ff @(posedge clk) begin
    if (reset || io_dec.flush_E || w_stall) begin
      r_ctrl_E  <= '0;
      r_rd1_E   <= '0;
      r_rd2_E   <= '0;
      r_imm_E   <= '0;
      r_rs_E    <= '0;
      r_rt_E    <= '0;
      r_rd_E    <= '0;
      r_pc_E    <= '0;
      r_funct_E <= '0;
      r_pxg_E   <= '0;
      r_pred_E  <= 1'b0;
      r_hit_E   <= 1'b0;
    end else begin
      r_ctrl_E  <= w_ctrl;
      r_rd1_E   <= w_rd1;
      r_rd2_E   <= w_rd2;
      r_imm_E   <= w_imm_ext;
      r_rs_E    <= w_rs;
      r_rt_E    <= w_rt;
      r_rd_E    <= w_rd;
      r_pc_E    <= io_dec.Pc_D;
      r_funct_E <= io_dec.Instr_D[5:0];
      r_pxg_E   <= io_dec.Pc_D[GHR_W-1:0] ^ io_dec.GHR_D;
      r_pred_E  <= io_dec.prediction_D;
      r_hit_E   <= io_dec.hit_D;
    end
  end

  assign io_dec.RD1_E        = r_rd1_E;
  assign io_dec.RD2_E        = r_rd2_E;
  assign io_dec.Imm_E        = r_imm_E;
  assign io_dec.Rs_E         = r_rs_E;
  assign io_dec.Rt_E         = r_rt_E;
  assign io_dec.Rd_E         = r_rd_E;
  assign io_dec.Pc_E         = r_pc_E;
  assign io_dec.functJR_E    = r_funct_E;
  assign io_dec.Pc_Xor_GR_E  = r_pxg_E;
  assign io_dec.ALUOp_E      = r_ctrl_E.alu_op;
  assign io_dec.rtype_E      = r_ctrl_E.rtype;
  assign io_dec.branch_E     = r_ctrl_E.branch;
  assign io_dec.bne_E        = r_ctrl_E.bne;
  assign io_dec.prediction_E = r_pred_E;
  assign io_dec.hit_E        = r_hit_E;
  assign io_dec.RegWrite_E   = r_ctrl_E.reg_write;
  assign io_dec.MemRead_E    = r_ctrl_E.mem_read;
  assign io_dec.MemWrite_E   = r_ctrl_E.mem_write;
  assign io_dec.MemtoReg_E   = r_ctrl_E.mem_to_reg;
  assign io_dec.ALUSrc_E     = r_ctrl_E.alu_src;
  assign io_dec.RegDst_E     = r_ctrl_E.reg_dst;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Directed cases for reset, write/read, same-cycle write-back, load-use,
//   flush, branch target/history and $0, followed by random traffic. Every
//   cycle is compared against a reference model (register array plus an
//   expected ID/EX record). Honours DECODE_WB_BYPASS_EN like the design.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if dif ();
  decode_stage u_dut (.clk(clk), .reset(reset), .io_dec(dif));

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd, pc;
    logic [5:0]  funct;
    logic [3:0]  pxg;
    logic [1:0]  aluop;
    logic rtype, branch, bne, pred, hit, rw, mr, mw, m2r, alusrc, regdst;
  } idex_t;

  logic [31:0] m_rf [32];
  idex_t       m_ex;

  // Control table: {RegWrite,RegDst,ALUSrc,MemRead,MemtoReg,MemWrite,branch,bne,rtype,ALUOp}
  function automatic logic [10:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 11'b1_1_0_0_0_0_0_0_1_10;
      6'h08:   return 11'b1_0_1_0_0_0_0_0_0_00;
      6'h23:   return 11'b1_0_1_1_1_0_0_0_0_00;
      6'h2B:   return 11'b0_0_1_0_0_1_0_0_0_00;
      6'h04:   return 11'b0_0_0_0_0_0_1_0_0_01;
      6'h05:   return 11'b0_0_0_0_0_0_1_1_0_01;
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (dif.RegWrite_W && dif.WriteReg_W == idx) return dif.Result_W;
`endif
    return m_rf[idx];
  endfunction

  function automatic idex_t zero_ex();
    idex_t z;
    z = '{default: 0};
    return z;
  endfunction

  // One clock: check combinational outputs, advance model, check ID/EX.
  task automatic step();
    idex_t nxt;
    logic [10:0] c;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic [31:0] imm, tgt;
    logic st, do_rst, we;
    logic [4:0] wa;
    logic [31:0] wd;
    #2;
    op  = dif.Instr_D[31:26];
    rs  = dif.Instr_D[25:21];
    rt  = dif.Instr_D[20:16];
    imm = 32'($signed(dif.Instr_D[15:0]));
    tgt = 32'(dif.Pc_D) + 32'd1 + imm;
    st  = m_ex.mr && (m_ex.rt != 0) && !dif.flush_E &&
          ((m_ex.rt == rs) || (m_ex.rt == rt && (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B)));
    check_val("opcode_D", 32'(dif.opcode_D), 32'(op));
    check_val("targetAddress_D", dif.targetAddress_D, tgt);
    check_val("IF_ID_write", 32'(dif.IF_ID_write), 32'(!st));
    check_val("PC_WRite", 32'(dif.PC_WRite), 32'(!st));
    if (reset || dif.flush_E || st) nxt = zero_ex();
    else begin
      c = ctrl_of(op);
      nxt.rd1 = m_read(rs); nxt.rd2 = m_read(rt); nxt.imm = imm;
      nxt.rs = rs; nxt.rt = rt; nxt.rd = dif.Instr_D[15:11]; nxt.pc = dif.Pc_D;
      nxt.funct = dif.Instr_D[5:0]; nxt.pxg = dif.Pc_D[3:0] ^ dif.GHR_D;
      nxt.pred = dif.prediction_D; nxt.hit = dif.hit_D;
      {nxt.rw, nxt.regdst, nxt.alusrc, nxt.mr, nxt.m2r, nxt.mw,
       nxt.branch, nxt.bne, nxt.rtype, nxt.aluop} = c;
    end
    do_rst = reset; we = dif.RegWrite_W; wa = dif.WriteReg_W; wd = dif.Result_W;
    @(posedge clk);
    #1;
    if (do_rst) for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    else if (we && wa != 0) m_rf[wa] = wd;
    m_ex = nxt;
    check_val("RD1_E", dif.RD1_E, m_ex.rd1);
    check_val("RD2_E", dif.RD2_E, m_ex.rd2);
    check_val("Imm_E", dif.Imm_E, m_ex.imm);
    check_val("Rs_E", 32'(dif.Rs_E), 32'(m_ex.rs));
    check_val("Rt_E", 32'(dif.Rt_E), 32'(m_ex.rt));
    check_val("Rd_E", 32'(dif.Rd_E), 32'(m_ex.rd));
    check_val("Pc_E", 32'(dif.Pc_E), 32'(m_ex.pc));
    check_val("functJR_E", 32'(dif.functJR_E), 32'(m_ex.funct));
    check_val("Pc_Xor_GR_E", 32'(dif.Pc_Xor_GR_E), 32'(m_ex.pxg));
    check_val("ALUOp_E", 32'(dif.ALUOp_E), 32'(m_ex.aluop));
    check_val("ctrl_E",
      32'({dif.rtype_E, dif.branch_E, dif.bne_E, dif.prediction_E, dif.hit_E, dif.RegWrite_E,
           dif.MemRead_E, dif.MemWrite_E, dif.MemtoReg_E, dif.ALUSrc_E, dif.RegDst_E}),
      32'({m_ex.rtype, m_ex.branch, m_ex.bne, m_ex.pred, m_ex.hit, m_ex.rw,
           m_ex.mr, m_ex.mw, m_ex.m2r, m_ex.alusrc, m_ex.regdst}));
    $display("cycle instr=%h pc=%0d flush=%0b rst=%0b wb=%0b/%0d/%h stall=%0b",
             dif.Instr_D, dif.Pc_D, dif.flush_E, do_rst, we, wa, wd, st);
  endtask

  task automatic drive(input logic [31:0] instr, input logic flush,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    dif.Instr_D = instr; dif.flush_E = flush;
    dif.RegWrite_W = we; dif.WriteReg_W = wa; dif.Result_W = wd;
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd, rs, rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  localparam logic [31:0] NOP = 32'hFC00_0000;
  logic [5:0] ops [7];

  initial begin
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
    m_ex = zero_ex();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    dif.Pc_D = 5'd0; dif.prediction_D = 1'b0; dif.hit_D = 1'b0; dif.GHR_D = 4'd0;
    drive(NOP, 1'b0, 1'b0, 5'd0, 32'd0);
    @(posedge clk); #1;

    // Reset
    reset = 1'b1; step(); reset = 1'b0;
    check_val("reset_ifid", 32'(dif.IF_ID_write), 32'd1);
    drive(r_add(5'd3, 5'd5, 5'd9), 1'b0, 1'b0, 5'd0, 32'd0); step();
    check_val("reset_rf_read", dif.RD1_E, 32'd0);

    // Write $5 then read it
    drive(NOP, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF); step();
    drive(r_add(5'd3, 5'd5, 5'd0), 1'b0, 1'b0, 5'd0, 32'd0); step();
    check_val("wr_rd_RD1", dif.RD1_E, 32'hDEADBEEF);
    check_val("wr_rd_RegDst", 32'(dif.RegDst_E), 32'd1);
    check_val("wr_rd_ALUOp", 32'(dif.ALUOp_E), 32'd2);

    // Same-cycle write-back and decode of $7
    drive(NOP, 1'b0, 1'b1, 5'd7, 32'h1111_1111); step();
    drive(r_add(5'd1, 5'd7, 5'd0), 1'b0, 1'b1, 5'd7, 32'h2222_2222); step();
`ifdef DECODE_WB_BYPASS_EN
    check_val("same_cycle_wb", dif.RD1_E, 32'h2222_2222);
`else
    check_val("same_cycle_wb", dif.RD1_E, 32'h1111_1111);
`endif

    // Load-use: one stall cycle with bubble, then the add issues
    drive({6'h23, 5'd1, 5'd2, 16'd0}, 1'b0, 1'b0, 5'd0, 32'd0); step();
    drive(r_add(5'd4, 5'd2, 5'd1), 1'b0, 1'b0, 5'd0, 32'd0);
    #2 check_val("lu_stall_ifid", 32'(dif.IF_ID_write), 32'd0);
    check_val("lu_stall_pcw", 32'(dif.PC_WRite), 32'd0);
    step();
    check_val("lu_bubble", 32'(dif.RegWrite_E), 32'd0);
    step();
    check_val("lu_issue", 32'(dif.RegWrite_E), 32'd1);
    check_val("lu_issue_rd", 32'(dif.Rd_E), 32'd4);

    // Same case under flush: no stall, bubble
    drive({6'h23, 5'd1, 5'd2, 16'd0}, 1'b0, 1'b0, 5'd0, 32'd0); step();
    drive(r_add(5'd4, 5'd2, 5'd1), 1'b1, 1'b0, 5'd0, 32'd0);
    #2 check_val("flush_no_stall", 32'(dif.IF_ID_write), 32'd1);
    step();
    check_val("flush_bubble", 32'(dif.RegWrite_E), 32'd0);

    // Branch target and history
    dif.Pc_D = 5'd5; dif.GHR_D = 4'b1010;
    drive({6'h04, 5'd1, 5'd2, 16'hFFFD}, 1'b0, 1'b0, 5'd0, 32'd0);
    #2 check_val("br_target", dif.targetAddress_D, 32'd3);
    step();
    check_val("br_branch", 32'(dif.branch_E), 32'd1);
    check_val("br_bne", 32'(dif.bne_E), 32'd0);
    check_val("br_pxg", 32'(dif.Pc_Xor_GR_E), 32'hF);

    // $0 protection
    drive(NOP, 1'b0, 1'b1, 5'd0, 32'h1234); step();
    drive(r_add(5'd3, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 32'd0); step();
    check_val("r0_read", dif.RD1_E, 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      dif.Instr_D = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 16'($urandom)};
      dif.Pc_D = 5'($urandom); dif.GHR_D = 4'($urandom);
      dif.prediction_D = 1'($urandom); dif.hit_D = 1'($urandom);
      dif.flush_E = ($urandom_range(0, 9) == 0);
      dif.RegWrite_W = 1'($urandom); dif.WriteReg_W = 5'($urandom_range(0, 3));
      dif.Result_W = $urandom;
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
